// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_pkg                                                         |
// | Brief   : Shared types and defaults for the data-memory responder.         |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    localparam int DEPTH_DEFAULT       = 32;
    localparam int WAIT_CYCLES_DEFAULT = 2;
    localparam int CNT_W               = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_array                                                       |
// | Brief   : Doubleword storage, sync write, comb read, sync clear.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEFAULT,
    parameter int IDX_W = idx_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [63:0]      i_wr_data,
    input  logic [IDX_W-1:0] i_rd_idx,
    output logic [63:0]      o_rd_data
);

    localparam logic [IDX_W:0] c_depth = (IDX_W + 1)'(DEPTH);

    logic [63:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && ({1'b0, i_wr_idx} < c_depth)) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    // Non-power-of-two depths leave index codes with no backing entry.
    always_comb begin
        o_rd_data = '0;
        if ({1'b0, i_rd_idx} < c_depth) begin
            o_rd_data = r_mem[i_rd_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dmem_responder                                                   |
// | Brief   : Single-outstanding load/store responder with fixed wait states.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH       = DEPTH_DEFAULT,
    parameter int WAIT_CYCLES = WAIT_CYCLES_DEFAULT
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int               c_idx_w     = idx_width(DEPTH);
    localparam logic [CNT_W-1:0] c_wait_init = CNT_W'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write;
    logic [63:0]        r_addr;
    logic [63:0]        r_wdata;
    logic [63:0]        r_rdata;
    logic               r_err;

    logic               w_idle;
    logic               w_accept;
    logic               w_op_write;
    logic [63:0]        w_op_addr;
    logic [63:0]        w_op_wdata;
    logic [60:0]        w_op_idx;
    logic               w_op_err;
    logic               w_enter_resp;
    logic               w_wr_en;
    logic [63:0]        w_rd_data;

    assign w_idle   = (r_state == ST_IDLE);
    assign w_accept = w_idle & req_valid;

    // With zero wait states RESP is entered on the accept edge itself,
    // so the operation must come straight from the request bus.
    assign w_op_write = w_idle ? req_write : r_write;
    assign w_op_addr  = w_idle ? req_addr  : r_addr;
    assign w_op_wdata = w_idle ? req_wdata : r_wdata;
    assign w_op_idx   = w_op_addr[63:3];
    assign w_op_err   = (w_op_addr[2:0] != 3'd0) || (w_op_idx >= 61'(DEPTH));

    assign w_enter_resp = (w_state_next == ST_RESP) && (r_state != ST_RESP);
    assign w_wr_en      = w_enter_resp & w_op_write & ~w_op_err;

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (c_idx_w)
    ) u_array (
        .clk       (CLK),
        .rst       (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (w_op_idx[c_idx_w-1:0]),
        .i_wr_data (w_op_wdata),
        .i_rd_idx  (w_op_idx[c_idx_w-1:0]),
        .o_rd_data (w_rd_data)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (req_valid) begin
                    w_state_next = (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_next = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready = w_idle;
        rsp_valid = (r_state == ST_RESP);
        rsp_rdata = r_rdata;
        rsp_err   = r_err;
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_write <= req_write;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                r_cnt   <= c_wait_init;
            end else if ((r_state == ST_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_enter_resp) begin
                r_err   <= w_op_err;
                r_rdata <= (w_op_write || w_op_err) ? 64'd0 : w_rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dmem_responder                                                |
// | Brief   : Directed self-checking bench for dmem_responder (WAIT 2 and 0).  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_dmem_responder;

    localparam logic [63:0] c_val = 64'h1234_5678_9ABC_DEF0;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        reset;
    logic        a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
    logic [63:0] a_req_addr, a_req_wdata, a_rsp_rdata;
    logic        z_req_valid, z_req_ready, z_req_write, z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [63:0] z_req_addr, z_req_wdata, z_rsp_rdata;

    int checks   = 0;
    int failures = 0;

    dmem_responder #(.DEPTH(32), .WAIT_CYCLES(2)) u_dut_a (
        .CLK(CLK), .reset(reset),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
        .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err)
    );

    dmem_responder #(.DEPTH(32), .WAIT_CYCLES(0)) u_dut_z (
        .CLK(CLK), .reset(reset),
        .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
        .req_addr(z_req_addr), .req_wdata(z_req_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready),
        .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
    );

    // Drives one request and returns the number of cycles until rsp_valid (-1 on timeout).
    task automatic issue(input bit z, input logic wr, input logic [63:0] addr,
                         input logic [63:0] wd, output int lat);
        @(negedge CLK);
        if (z) begin z_req_valid = 1'b1; z_req_write = wr; z_req_addr = addr; z_req_wdata = wd; end
        else   begin a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr; a_req_wdata = wd; end
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLK);
            if (n == 1) begin
                // Garbage on the bus after the accept cycle must be ignored.
                if (z) begin z_req_valid = 1'b0; z_req_addr = 64'h3; z_req_wdata = '1; z_req_write = ~wr; end
                else   begin a_req_valid = 1'b0; a_req_addr = 64'h3; a_req_wdata = '1; a_req_write = ~wr; end
            end
            if ((z ? z_rsp_valid : a_rsp_valid) === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic release_rsp(input bit z);
        if (z) z_rsp_ready = 1'b1; else a_rsp_ready = 1'b1;
        @(negedge CLK);
        if (z) z_rsp_ready = 1'b0; else a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge CLK);
        reset = 1'b0;
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", a_req_ready); end
        checks++; if (a_rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); end
        checks++; if (a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL reset_rsp_rdata got=%h exp=0", a_rsp_rdata); end
        checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("FAIL reset_rsp_err got=%b exp=0", a_rsp_err); end
        checks++; if (z_req_ready !== 1'b1) begin failures++; $display("FAIL reset_z_req_ready got=%b exp=1", z_req_ready); end
    endtask

    task automatic test_store_load();
        int lat;
        issue(1'b0, 1'b1, 64'h28, c_val, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL store_latency got=%0d exp=3", lat); end
        checks++; if (a_rsp_err !== 1'b0 || a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL store_rsp got err=%b data=%h exp err=0 data=0", a_rsp_err, a_rsp_rdata); end
        release_rsp(1'b0);
        checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL store_idle got=%b exp=1", a_req_ready); end
        issue(1'b0, 1'b0, 64'h28, 64'd0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL load_latency got=%0d exp=3", lat); end
        checks++; if (a_rsp_rdata !== c_val) begin failures++; $display("FAIL load_data got=%h exp=%h", a_rsp_rdata, c_val); end
        checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("FAIL load_err got=%b exp=0", a_rsp_err); end
        release_rsp(1'b0);
    endtask

    task automatic test_misaligned();
        int lat;
        issue(1'b0, 1'b1, 64'h2C, 64'hF, lat);
        checks++; if (lat !== 3 || a_rsp_err !== 1'b1) begin failures++; $display("FAIL misaligned_err got lat=%0d err=%b exp lat=3 err=1", lat, a_rsp_err); end
        checks++; if (a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL misaligned_data got=%h exp=0", a_rsp_rdata); end
        release_rsp(1'b0);
        issue(1'b0, 1'b0, 64'h28, 64'd0, lat);
        checks++; if (a_rsp_rdata !== c_val || a_rsp_err !== 1'b0) begin failures++; $display("FAIL misaligned_keep got data=%h err=%b exp data=%h err=0", a_rsp_rdata, a_rsp_err, c_val); end
        release_rsp(1'b0);
    endtask

    task automatic test_out_of_range();
        int lat;
        issue(1'b0, 1'b0, 64'h100, 64'd0, lat);
        checks++; if (a_rsp_err !== 1'b1) begin failures++; $display("FAIL oor_err got=%b exp=1", a_rsp_err); end
        checks++; if (a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL oor_data got=%h exp=0", a_rsp_rdata); end
        release_rsp(1'b0);
        // Last valid index must still be reachable.
        issue(1'b0, 1'b1, 64'hF8, 64'hA5A5, lat);
        checks++; if (a_rsp_err !== 1'b0) begin failures++; $display("FAIL top_index_err got=%b exp=0", a_rsp_err); end
        release_rsp(1'b0);
        issue(1'b0, 1'b0, 64'hF8, 64'd0, lat);
        checks++; if (a_rsp_rdata !== 64'hA5A5) begin failures++; $display("FAIL top_index_data got=%h exp=a5a5", a_rsp_rdata); end
        release_rsp(1'b0);
    endtask

    task automatic test_backpressure();
        int lat;
        issue(1'b0, 1'b0, 64'h28, 64'd0, lat);
        checks++; if (lat !== 3) begin failures++; $display("FAIL bp_latency got=%0d exp=3", lat); end
        for (int k = 0; k < 5; k++) begin
            @(negedge CLK);
            checks++;
            if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== c_val || a_req_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold cyc=%0d got valid=%b data=%h ready=%b exp valid=1 data=%h ready=0",
                         k, a_rsp_valid, a_rsp_rdata, a_req_ready, c_val);
            end
        end
        release_rsp(1'b0);
        checks++; if (a_req_ready !== 1'b1 || a_rsp_valid !== 1'b0) begin failures++; $display("FAIL bp_release got ready=%b valid=%b exp ready=1 valid=0", a_req_ready, a_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit seen;
        @(negedge CLK);
        a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 64'h08; a_req_wdata = 64'hFF;
        @(negedge CLK);
        a_req_valid = 1'b0;
        checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL mid_in_wait got ready=%b exp=0", a_req_ready); end
        reset = 1'b1;
        @(negedge CLK);
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (a_rsp_valid !== 1'b0) seen = 1'b1;
            @(negedge CLK);
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL mid_no_response got=1 exp=0"); end
        issue(1'b0, 1'b0, 64'h08, 64'd0, lat);
        checks++; if (lat !== 3 || a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL mid_no_store got lat=%0d data=%h exp lat=3 data=0", lat, a_rsp_rdata); end
        release_rsp(1'b0);
        issue(1'b0, 1'b0, 64'h28, 64'd0, lat);
        checks++; if (a_rsp_rdata !== 64'd0) begin failures++; $display("FAIL mid_array_clear got=%h exp=0", a_rsp_rdata); end
        release_rsp(1'b0);
    endtask

    task automatic test_wait0();
        int lat;
        issue(1'b1, 1'b1, 64'h10, 64'hAA, lat);
        checks++; if (lat !== 1) begin failures++; $display("FAIL w0_store_latency got=%0d exp=1", lat); end
        release_rsp(1'b1);
        issue(1'b1, 1'b0, 64'h10, 64'd0, lat);
        checks++; if (lat !== 1 || z_rsp_rdata !== 64'hAA) begin failures++; $display("FAIL w0_load got lat=%0d data=%h exp lat=1 data=aa", lat, z_rsp_rdata); end
        release_rsp(1'b1);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        @(negedge CLK);
        z_req_valid = 1'b1; z_req_write = 1'b0; z_req_addr = 64'h10; z_rsp_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checks++;
            if (z_req_ready !== ((k % 2) == 0) || z_rsp_valid !== ((k % 2) == 1)) begin
                failures++;
                $display("FAIL b2b_phase cyc=%0d got ready=%b valid=%b exp ready=%b valid=%b",
                         k, z_req_ready, z_rsp_valid, (k % 2) == 0, (k % 2) == 1);
            end
            if ((k % 2) == 1) begin
                checks++;
                if (z_rsp_rdata !== 64'hAA) begin failures++; $display("FAIL b2b_data cyc=%0d got=%h exp=aa", k, z_rsp_rdata); end
            end
            if (z_req_ready === 1'b1) accepts++;
            @(negedge CLK);
        end
        z_req_valid = 1'b0; z_rsp_ready = 1'b0;
        checks++; if (accepts !== 4) begin failures++; $display("FAIL b2b_accepts got=%0d exp=4", accepts); end
    endtask

    initial begin
        reset = 1'b1;
        a_req_valid = 1'b0; a_req_write = 1'b0; a_req_addr = '0; a_req_wdata = '0; a_rsp_ready = 1'b0;
        z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_rsp_ready = 1'b0;
        test_reset();
        test_store_load();
        test_misaligned();
        test_out_of_range();
        test_backpressure();
        test_reset_mid();
        test_wait0();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
